// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// default reset PC and instruction word width.
package ifu_pkg;

    localparam int          INS_W            = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } ifu_state_t;

    // A next PC is usable only when it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Holds the PC, issues one instruction fetch at a
// time, and presents the returned word to decode until it is accepted.
// The next PC comes from the downstream npc block and is taken on accept;
// a misaligned next PC parks the unit in a terminal fault state.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [INS_W-1:0] ins,
    output logic [31:0]      iaddr,
    input  logic [31:0]      niaddr,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_t       state_r;
    ifu_state_t       state_nxt_s;
    logic [31:0]      pc_r;
    logic [INS_W-1:0] ins_r;
    logic [CNT_W-1:0] fetch_cnt_r;
    logic             fault_r;
    logic             accept_s;
    logic             bad_next_s;

    assign accept_s   = (state_r == HOLD) && ins_ready;
    assign bad_next_s = is_misaligned(niaddr);

    // Next-state decode; gnt/rvalid only matter in the state that expects them.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            REQ: begin
                if (imem_gnt) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (!ins_ready) begin
                    state_nxt_s = HOLD;
                end else if (bad_next_s) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            FAULT: begin
                state_nxt_s = FAULT;
            end
            default: begin
                state_nxt_s = REQ;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC: loads the npc result on accept, otherwise stays put so npc sees stable inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (accept_s) begin
            pc_r <= niaddr;
        end
    end

    // Instruction register: captured only on the response while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_r <= {INS_W{1'b0}};
        end else if ((state_r == WAIT) && imem_rvalid) begin
            ins_r <= imem_rdata;
        end
    end

    // Accepted-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            fetch_cnt_r <= fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky fault flag, set together with the move into FAULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (accept_s && bad_next_s) begin
            fault_r <= 1'b1;
        end
    end

    assign imem_req  = (state_r == REQ);
    assign ins_valid = (state_r == HOLD);
    assign imem_addr = pc_r;
    assign iaddr     = pc_r;
    assign ins       = ins_r;
    assign fault     = fault_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. A second instance with a 4-bit counter is
// driven by the same stimulus to observe counter wrap.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_ready;
    logic [31:0] niaddr;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] iaddr;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_ins_valid;
    logic [31:0] w_ins;
    logic [31:0] w_iaddr;
    logic        w_fault;
    logic [3:0]  w_fetch_cnt;

    int n_checks;
    int n_errors;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .iaddr(iaddr),
        .niaddr(niaddr), .fault(fault), .fetch_cnt(fetch_cnt)
    );

    ifu_fetch #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(w_ins_valid), .ins_ready(ins_ready), .ins(w_ins), .iaddr(w_iaddr),
        .niaddr(niaddr), .fault(w_fault), .fetch_cnt(w_fetch_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; ins_ready = 1'b0;
        step();
        check("rst_req",   {31'd0, imem_req},  32'd1);
        check("rst_addr",  imem_addr,          32'h0000_3000);
        check("rst_valid", {31'd0, ins_valid}, 32'd0);
        check("rst_fault", {31'd0, fault},     32'd0);
        check("rst_cnt",   fetch_cnt,          32'd0);
        check("rst_ins",   ins,                32'd0);
        rst = 1'b0;
    endtask

    // One fetch with zero gnt/rvalid delay and immediate accept: 3 cycles.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word,
                            input logic [31:0] next);
        check("f_req",  {31'd0, imem_req}, 32'd1);
        check("f_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("f_wait_req",   {31'd0, imem_req},  32'd0);
        check("f_wait_valid", {31'd0, ins_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check("f_hold_valid", {31'd0, ins_valid}, 32'd1);
        check("f_hold_iaddr", iaddr, addr);
        check("f_hold_ins",   ins, word);
        ins_ready = 1'b1;
        niaddr    = next;
        step();
        ins_ready = 1'b0;
        niaddr    = $urandom;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        ins_ready = 1'b0; niaddr = 32'd0;
        step();
        do_reset();

        // First fetch right after reset release.
        do_fetch(32'h0000_3000, 32'h2008_0005, 32'h0000_3004);
        check("t1_cnt",   fetch_cnt, 32'd1);
        check("t1_valid", {31'd0, ins_valid}, 32'd0);

        // Sequential run of four instructions.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'h0000_3000 + 32'(i * 4), 32'h1000_0000 + 32'(i),
                     32'h0000_3004 + 32'(i * 4));
        end
        check("seq_cnt",  fetch_cnt, 32'd4);
        check("seq_addr", imem_addr, 32'h0000_3010);

        // Backpressure in HOLD for 5 cycles.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            niaddr   = $urandom;
            imem_gnt = 1'b1;
            step();
            check("bp_valid", {31'd0, ins_valid}, 32'd1);
            check("bp_req",   {31'd0, imem_req},  32'd0);
            check("bp_ins",   ins,   32'hCAFE_0001);
            check("bp_iaddr", iaddr, 32'h0000_3010);
        end
        imem_gnt  = 1'b0;
        ins_ready = 1'b1;
        niaddr    = 32'h0000_3100;
        step();
        ins_ready = 1'b0;
        check("bp_next_addr", imem_addr, 32'h0000_3100);
        check("bp_next_req",  {31'd0, imem_req}, 32'd1);
        check("bp_cnt",       fetch_cnt, 32'd5);

        // Misaligned next PC leads to a terminal fault.
        do_fetch(32'h0000_3100, 32'h0BAD_0000, 32'h0000_3102);
        check("mis_fault", {31'd0, fault},     32'd1);
        check("mis_req",   {31'd0, imem_req},  32'd0);
        check("mis_valid", {31'd0, ins_valid}, 32'd0);
        check("mis_addr",  imem_addr, 32'h0000_3102);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; ins_ready = 1'b1; niaddr = 32'h0000_4000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mis_hold_fault", {31'd0, fault},     32'd1);
            check("mis_hold_req",   {31'd0, imem_req},  32'd0);
            check("mis_hold_valid", {31'd0, ins_valid}, 32'd0);
            check("mis_hold_addr",  imem_addr, 32'h0000_3102);
        end
        check("mis_cnt", fetch_cnt, 32'd6);
        do_reset();

        // Reset while WAITing; stale response after release must be dropped.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("rw_wait_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        #1;
        check("rw_async_req",  {31'd0, imem_req}, 32'd1);
        check("rw_async_addr", imem_addr, 32'h0000_3000);
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("rw_stale_valid", {31'd0, ins_valid}, 32'd0);
        check("rw_stale_req",   {31'd0, imem_req},  32'd1);
        check("rw_stale_ins",   ins, 32'd0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        check("rw_nodata_valid", {31'd0, ins_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        check("rw_new_valid", {31'd0, ins_valid}, 32'd1);
        check("rw_new_ins",   ins, 32'h1234_5678);
        check("rw_new_iaddr", iaddr, 32'h0000_3000);
        ins_ready = 1'b1;
        niaddr    = 32'h0000_3004;
        step();
        ins_ready = 1'b0;
        check("rw_cnt", fetch_cnt, 32'd1);

        // Counter wrap on the 4-bit instance after 17 accepts.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_fetch(32'h0000_3000 + 32'(i * 4), 32'(i), 32'h0000_3004 + 32'(i * 4));
        end
        check("wrap_cnt4",  {28'd0, w_fetch_cnt}, 32'd1);
        check("wrap_cnt32", fetch_cnt, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: holds the program counter, fetches one instruction word at a time from instruction memory over a request/response handshake, and presents `ins`/`iaddr` to decode under a valid/ready handshake. It sits directly upstream of `npc`, which computes `niaddr` from the presented `iaddr`/`ins`. When decode accepts the instruction, `ifu_fetch` loads that `niaddr` as the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `CNT_W`, default 32: width of the fetch counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the request; equals `pc`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid. Arrives at least 1 cycle after the grant.
- `imem_rdata` in 32: instruction word.
- `ins_valid` out 1: `ins`/`iaddr` valid for decode.
- `ins_ready` in 1: decode accepts.
- `ins` out 32: fetched instruction.
- `iaddr` out 32: address of `ins`.
- `niaddr` in 32: next PC from `npc`. Sampled only on accept.
- `fault` out 1: misaligned next PC detected. Sticky.
- `fetch_cnt` out CNT_W: count of accepted instructions.

## Operation
- FSM states and transitions:
  - REQ: `imem_req`=1. Goes to WAIT on `imem_gnt`.
  - WAIT: goes to HOLD on `imem_rvalid`. `ins` <= `imem_rdata`.
  - HOLD: `ins_valid`=1. Leaves on accept (`ins_valid && ins_ready`).
  - FAULT: terminal.
- On accept:
  - `pc` <= `niaddr`.
  - `fetch_cnt` increments and wraps modulo 2^CNT_W.
  - If `niaddr[1:0]` != 0, go to FAULT and set `fault`=1. Otherwise go to REQ.
- FAULT:
  - `imem_req`=0 and `ins_valid`=0.
  - `pc` holds the offending `niaddr`; `imem_addr` shows it.
  - Exit only by reset.
- Only one request is ever outstanding. There is no speculative PC+4 prefetch, because `niaddr` depends on the current instruction.
- `iaddr` is always equal to `pc`. It is stable in WAIT and HOLD, so `npc` sees constant inputs while `ins_valid` is high.
- `ins` is registered. It changes only on the WAIT-state `imem_rvalid` edge.
- `imem_rvalid` outside WAIT is ignored. This covers a stale response from a request issued before a mid-operation reset, which is dropped.
- `imem_gnt` outside REQ is ignored.
- Reset values:
  - state = REQ, `pc` = RESET_PC.
  - `ins` = 0, `fetch_cnt` = 0, `fault` = 0.
  - Therefore `imem_req` = 1, `imem_addr` = RESET_PC, `ins_valid` = 0.
- Reset mid-operation (any state) returns immediately to the reset values. A pending HOLD instruction is discarded.

## Timing
- `imem_req` is high in the first clock after `rst` deasserts. It stays high until the `imem_gnt` edge.
- Grant in cycle t (state REQ) puts the FSM in WAIT at t+1. `imem_rvalid` in cycle t+k (k≥1) puts it in HOLD at t+k+1.
- Accept in cycle h puts the new `pc` and REQ at h+1.
- Best-case throughput is 3 cycles per instruction: gnt in c0, rvalid in c1, accept in c2.
- `imem_req`, `ins_valid` and `fault` are decoded from registered state only. There is no combinational path from `ins_ready`/`imem_gnt` to them.
- `niaddr` is sampled only on the accept edge. Its value in all other cycles is don't-care.

## Structure
- Shared package `ifu_pkg` holds:
  - the state enum `ifu_state_t` {REQ, WAIT, HOLD, FAULT};
  - `RESET_PC_DEFAULT` = 32'h0000_3000;
  - `INS_W` = 32.
- Single module. No sub-module is warranted. The PC register, FSM, and counter are each a few always blocks.

## Test plan
- Reset release, `imem_gnt`=1 immediately, `imem_rvalid` next cycle with 32'h2008_0005, `ins_ready`=1: `imem_addr`=32'h0000_3000; `ins_valid` rises 2 cycles after release with `iaddr`=32'h3000; `fetch_cnt`=1 after accept.
- Sequential run with `niaddr`=`iaddr`+4, 4 instructions, 0-cycle gnt/rvalid delays: addresses 3000, 3004, 3008, 300C; exactly 3 cycles per instruction; `fetch_cnt`=4.
- Backpressure: `ins_ready`=0 for 5 cycles in HOLD, then 1: `ins`/`iaddr` stable throughout; no `imem_req` until the cycle after accept; `niaddr`=32'h0000_3100 is taken as the next `imem_addr`.
- Misaligned `niaddr`=32'h0000_3102 on accept: `fault`=1 next cycle; `imem_req`=0 and `ins_valid`=0 forever; `imem_addr`=32'h3102; cleared only by `rst`.
- Reset in WAIT, stale `imem_rvalid` 1 cycle after release: response ignored; new request to 32'h3000; `ins_valid` stays 0 until the new rvalid.
- `CNT_W`=4, 17 accepts: `fetch_cnt` wraps to 1.
